// File: rtl/trace_collector.sv
// Retirement-trace collector: queues W-stage register writes and M-stage stores in program order.
// Latency 1 cycle push-to-output; 2 pushes + 1 pop per cycle; when full, records are dropped and counted.
// Optional macro TRACE_SKIP_R0_EN: GRF writes to $0 are ignored (neither queued nor counted).
module trace_collector #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             grf_we,
    input  logic [31:0]      grf_pc,
    input  logic [4:0]       grf_addr,
    input  logic [31:0]      grf_wd,
    input  logic [3:0]       dm_we,
    input  logic [31:0]      dm_pc,
    input  logic [31:0]      dm_addr,
    input  logic [31:0]      dm_wd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_type,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_data,
    output logic [3:0]       out_be,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 2;

    typedef struct packed {
        logic        typ;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } rec_t;

    rec_t             mem_q [DEPTH];
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             grf_cand, dm_cand, pop, push_grf, push_dm;
    logic [FW-1:0]    free_slots;
    logic [1:0]       n_drop;
    logic [AW-1:0]    dm_slot;
    logic [CNT_W:0]   drop_sum;
    rec_t             grf_rec, dm_rec;

    always_comb begin
`ifdef TRACE_SKIP_R0_EN
        grf_cand = grf_we && (grf_addr != 5'd0);
`else
        grf_cand = grf_we;
`endif
        dm_cand    = (dm_we != 4'd0);
        pop        = (count_q != '0) && out_ready;
        // A same-cycle pop frees a slot for this edge's pushes.
        free_slots = FW'(DEPTH) - FW'(count_q) + FW'(pop);
        push_grf   = grf_cand && (free_slots != '0);
        push_dm    = dm_cand && (free_slots >= (grf_cand ? FW'(2) : FW'(1)));
        n_drop     = 2'(grf_cand && !push_grf) + 2'(dm_cand && !push_dm);

        grf_rec = '{typ: 1'b0, pc: grf_pc, addr: {27'd0, grf_addr}, data: grf_wd, be: 4'hF};
        dm_rec  = '{typ: 1'b1, pc: dm_pc, addr: dm_addr, data: dm_wd, be: dm_we};

        // The older W-stage record takes wptr; the store lands just behind it.
        dm_slot = wptr_q + AW'(push_grf);
        wptr_d  = wptr_q + AW'(push_grf) + AW'(push_dm);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + (AW+1)'(push_grf) + (AW+1)'(push_dm) - (AW+1)'(pop);

        overflow_d = overflow_q | (n_drop != 2'd0);
        drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(n_drop);
        drop_cnt_d = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            if (push_grf) begin
                mem_q[wptr_q] <= grf_rec;
            end
            if (push_dm) begin
                mem_q[dm_slot] <= dm_rec;
            end
        end
    end

    assign out_valid = (count_q != '0);
    assign out_type  = mem_q[rptr_q].typ;
    assign out_pc    = mem_q[rptr_q].pc;
    assign out_addr  = mem_q[rptr_q].addr;
    assign out_data  = mem_q[rptr_q].data;
    assign out_be    = mem_q[rptr_q].be;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_trace_collector.sv
// Self-checking bench for trace_collector: directed scenarios plus a randomized run against a queue model.
module tb_trace_collector;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic        typ;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } rec_t;

    logic             clk, reset;
    logic             grf_we;
    logic [31:0]      grf_pc, grf_wd;
    logic [4:0]       grf_addr;
    logic [3:0]       dm_we;
    logic [31:0]      dm_pc, dm_addr, dm_wd;
    logic             out_valid, out_ready, out_type;
    logic [31:0]      out_pc, out_addr, out_data;
    logic [3:0]       out_be;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;
    rec_t             obs;

    int   checks = 0;
    int   failures = 0;
    int   exp_drop = 0;
    rec_t sb[$];
    rec_t exp_r;

    trace_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wd(grf_wd),
        .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wd(dm_wd),
        .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
        .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data), .out_be(out_be),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    assign obs = {out_type, out_pc, out_addr, out_data, out_be};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic rec_t mk_grf(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] wd);
        return {1'b0, pc, {27'd0, a}, wd, 4'hF};
    endfunction

    function automatic rec_t mk_dm(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] wd,
                                   input logic [3:0] be);
        return {1'b1, pc, a, wd, be};
    endfunction

    function automatic bit grf_is_cand(input logic we, input logic [4:0] a);
`ifdef TRACE_SKIP_R0_EN
        return we && (a != 5'd0);
`else
        return we && (a == a);
`endif
    endfunction

    task automatic set_grf(input logic we, input logic [31:0] pc, input logic [4:0] a, input logic [31:0] wd);
        grf_we = we; grf_pc = pc; grf_addr = a; grf_wd = wd;
    endtask

    task automatic set_dm(input logic [3:0] we, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] wd);
        dm_we = we; dm_pc = pc; dm_addr = a; dm_wd = wd;
    endtask

    task automatic idle();
        grf_we = 1'b0;
        dm_we  = 4'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle(); out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (obs !== '0) begin failures++; $display("FAIL reset_payload got=%h exp=0", obs); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (drop_cnt !== '0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
        reset = 1'b0;
        sb.delete();
        exp_drop = 0;
    endtask

    task automatic test_single_grf();
        out_ready = 1'b1;
        set_grf(1'b1, 32'h3000, 5'd8, 32'h1234);
        sb.push_back(mk_grf(32'h3000, 5'd8, 32'h1234));
        @(negedge clk); idle();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        exp_r = sb.pop_front();
        checks++; if (obs !== exp_r) begin failures++; $display("FAIL single_rec got=%h exp=%h", obs, exp_r); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_dual_push();
        out_ready = 1'b0;
        set_grf(1'b1, 32'h3008, 5'd9, 32'hAAAA);
        set_dm(4'h3, 32'h300C, 32'h10, 32'hBBBB);
        sb.push_back(mk_grf(32'h3008, 5'd9, 32'hAAAA));
        sb.push_back(mk_dm(32'h300C, 32'h10, 32'hBBBB, 4'h3));
        @(negedge clk); idle();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid !== 1'b1 || obs !== sb[0]) begin
                failures++; $display("FAIL dual_hold v=%b got=%h exp=%h", out_valid, obs, sb[0]);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            if (out_valid) begin
                exp_r = sb.pop_front(); checks++;
                if (obs !== exp_r) begin failures++; $display("FAIL dual_drain got=%h exp=%h", obs, exp_r); end
            end
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL dual_end left=%0d valid=%b exp left=0 valid=0", sb.size(), out_valid);
        end
    endtask

    task automatic test_fill_overflow();
        int n;
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            set_grf(1'b1, 32'h4000 + 32'(4 * i), 5'(i + 1), 32'h100 + 32'(i));
            sb.push_back(mk_grf(32'h4000 + 32'(4 * i), 5'(i + 1), 32'h100 + 32'(i)));
            @(negedge clk);
        end
        set_grf(1'b1, 32'h401C, 5'd20, 32'h1FF);
        set_dm(4'hF, 32'h4020, 32'h80, 32'h2FF);
        sb.push_back(mk_grf(32'h401C, 5'd20, 32'h1FF));
        exp_drop++;
        @(negedge clk); idle();
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow got=%b exp=1", overflow); end
        checks++;
        if (drop_cnt !== CNT_W'(exp_drop)) begin failures++; $display("FAIL fill_drop_cnt got=%0d exp=%0d", drop_cnt, exp_drop); end
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            if (out_valid) begin
                exp_r = sb.pop_front(); checks++; n++;
                if (obs !== exp_r) begin failures++; $display("FAIL fill_drain got=%h exp=%h", obs, exp_r); end
            end
            @(negedge clk);
        end
        checks++;
        if (n != 8 || out_valid !== 1'b0) begin failures++; $display("FAIL fill_end drained=%0d valid=%b exp 8 and 0", n, out_valid); end
    endtask

    task automatic test_full_with_pop();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_grf(1'b1, 32'h5000 + 32'(4 * i), 5'(i + 1), 32'h500 + 32'(i));
            sb.push_back(mk_grf(32'h5000 + 32'(4 * i), 5'(i + 1), 32'h500 + 32'(i)));
            @(negedge clk);
        end
        idle();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL full_valid got=%b exp=1", out_valid); end
        out_ready = 1'b1;
        exp_r = sb.pop_front();
        checks++; if (obs !== exp_r) begin failures++; $display("FAIL full_pop_rec got=%h exp=%h", obs, exp_r); end
        set_grf(1'b1, 32'h5020, 5'd30, 32'h5555);
        sb.push_back(mk_grf(32'h5020, 5'd30, 32'h5555));
        @(negedge clk);
        checks++;
        if (drop_cnt !== CNT_W'(exp_drop)) begin failures++; $display("FAIL full_pop_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
        // Queue should still be full, so this one must be dropped.
        out_ready = 1'b0;
        set_grf(1'b1, 32'h5024, 5'd31, 32'h6666);
        exp_drop++;
        @(negedge clk); idle();
        checks++;
        if (drop_cnt !== CNT_W'(exp_drop)) begin failures++; $display("FAIL full_still_full got=%0d exp=%0d", drop_cnt, exp_drop); end
        out_ready = 1'b1;
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            if (out_valid) begin
                exp_r = sb.pop_front(); checks++;
                if (obs !== exp_r) begin failures++; $display("FAIL full_drain got=%h exp=%h", obs, exp_r); end
            end
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL full_end left=%0d valid=%b exp left=0 valid=0", sb.size(), out_valid);
        end
    endtask

    task automatic test_r0_filter();
        out_ready = 1'b1;
        set_grf(1'b1, 32'h6000, 5'd0, 32'hDEAD);
        if (grf_is_cand(1'b1, 5'd0)) sb.push_back(mk_grf(32'h6000, 5'd0, 32'hDEAD));
        @(negedge clk); idle();
        checks++;
        if (out_valid !== (sb.size() != 0)) begin failures++; $display("FAIL r0_valid got=%b exp=%b", out_valid, sb.size() != 0); end
        if (sb.size() != 0) begin
            exp_r = sb.pop_front(); checks++;
            if (obs !== exp_r) begin failures++; $display("FAIL r0_rec got=%h exp=%h", obs, exp_r); end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL r0_empty got=%b exp=0", out_valid); end
        checks++;
        if (drop_cnt !== CNT_W'(exp_drop)) begin failures++; $display("FAIL r0_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_grf(1'b1, 32'h7000 + 32'(4 * i), 5'(i + 1), 32'h700 + 32'(i));
            @(negedge clk);
        end
        idle();
        checks++;
        if (out_valid !== 1'b1 || overflow !== 1'b1) begin
            failures++; $display("FAIL mid_pre valid=%b ovf=%b exp 1 and 1", out_valid, overflow);
        end
        reset = 1'b1;
        out_ready = 1'b1;
        set_grf(1'b1, 32'h7777, 5'd3, 32'h7777);
        @(negedge clk);
        reset = 1'b0; idle(); out_ready = 1'b0;
        sb.delete(); exp_drop = 0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL mid_overflow got=%b exp=0", overflow); end
        checks++; if (drop_cnt !== '0) begin failures++; $display("FAIL mid_drop got=%0d exp=0", drop_cnt); end
        set_grf(1'b1, 32'h7100, 5'd4, 32'h4444);
        sb.push_back(mk_grf(32'h7100, 5'd4, 32'h4444));
        @(negedge clk); idle();
        exp_r = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || obs !== exp_r) begin failures++; $display("FAIL mid_next v=%b got=%h exp=%h", out_valid, obs, exp_r); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_alone got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 400; c++) begin
            logic        g_we, rdy;
            logic [4:0]  ga;
            logic [3:0]  dwe;
            logic [31:0] gpc, gwd, dpc, da, dwd;
            int          free;
            g_we = 1'($urandom_range(0, 1));
            ga   = 5'($urandom_range(0, 31));
            dwe  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            rdy  = (c < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            gpc = 32'h8000 + 32'(8 * c); gwd = $urandom;
            dpc = gpc + 32'd4; da = {$urandom_range(0, 255), 2'b00}; dwd = $urandom;
            checks++;
            if (out_valid !== (sb.size() != 0)) begin
                failures++; $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", c, out_valid, sb.size() != 0);
            end
            if (sb.size() != 0 && rdy) begin
                exp_r = sb.pop_front(); checks++;
                if (obs !== exp_r) begin failures++; $display("FAIL b2b_rec cyc=%0d got=%h exp=%h", c, obs, exp_r); end
            end
            free = DEPTH - sb.size();
            if (grf_is_cand(g_we, ga)) begin
                if (free > 0) begin sb.push_back(mk_grf(gpc, ga, gwd)); free--; end
                else exp_drop++;
            end
            if (dwe != 4'd0) begin
                if (free > 0) sb.push_back(mk_dm(dpc, da, dwd, dwe));
                else exp_drop++;
            end
            set_grf(g_we, gpc, ga, gwd);
            set_dm(dwe, dpc, da, dwd);
            out_ready = rdy;
            @(negedge clk);
        end
        idle();
        checks++;
        if (drop_cnt !== CNT_W'(exp_drop)) begin failures++; $display("FAIL b2b_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
        checks++;
        if (overflow !== (exp_drop != 0)) begin failures++; $display("FAIL b2b_overflow got=%b exp=%b", overflow, exp_drop != 0); end
        out_ready = 1'b1;
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            if (out_valid) begin
                exp_r = sb.pop_front(); checks++;
                if (obs !== exp_r) begin failures++; $display("FAIL b2b_drain got=%h exp=%h", obs, exp_r); end
            end
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_end left=%0d valid=%b exp left=0 valid=0", sb.size(), out_valid);
        end
    endtask

    initial begin
        reset = 1'b1; out_ready = 1'b0;
        set_grf(1'b0, '0, '0, '0);
        set_dm(4'd0, '0, '0, '0);
        @(negedge clk);
        test_reset();
        test_single_grf();
        test_dual_push();
        test_fill_overflow();
        test_full_with_pop();
        test_r0_filter();
        test_reset_midstream();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/trace_collector.md
# trace_collector

Synthesizable retirement-trace collector for the P5 five-stage pipelined MIPS core. It captures register-file writes from the W stage and data-memory writes from the M stage and queues them in program order. A consumer (an on-chip checker or a debug UART) drains the records over a valid/ready interface. It is the reading end of the CPU's architectural-write stream that the simulation bench otherwise only prints.

## Interface
Parameters:
- DEPTH, 8: number of FIFO entries; power of two, minimum 2.
- CNT_W, 16: width of the dropped-record counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- grf_we  input  1  W-stage register write strobe.
- grf_pc  input  32  PC of the W-stage instruction.
- grf_addr  input  5  destination register number.
- grf_wd  input  32  data written to the register.
- dm_we  input  4  M-stage byte enables; nonzero means a store.
- dm_pc  input  32  PC of the M-stage instruction.
- dm_addr  input  32  word-aligned store address.
- dm_wd  input  32  store data, already lane-aligned.
- out_valid  output  1  a record is presented.
- out_ready  input  1  consumer accepts the record this cycle.
- out_type  output  1  0 = register write, 1 = memory write.
- out_pc  output  32  PC of the record.
- out_addr  output  32  register number (zero-extended) or memory address.
- out_data  output  32  written data.
- out_be  output  4  byte enables; 4'b1111 for register records.
- overflow  output  1  sticky flag; set when any record has been dropped.
- drop_cnt  output  CNT_W  number of dropped records, saturating.

## Operation
- Circular FIFO of DEPTH entries, each holding {type, pc, addr, data, be}. It uses a read pointer, a write pointer and an occupancy count of width log2(DEPTH)+1.
- Push candidates each cycle:
  - GRF record when grf_we=1, subject to the $0 filter in Configuration.
  - DM record when dm_we != 0.
- When both are candidates in the same cycle, the GRF record is written first (slot wptr) and the DM record second (slot wptr+1). The W-stage instruction is older, so this preserves program order.
- Pop occurs when out_valid && out_ready.
- Free slots for this edge = DEPTH − count + pop. A same-cycle pop frees a slot for a push.
- If free ≥ candidates, all candidates are pushed.
- If free = 1 and there are two candidates, the GRF record is pushed and the DM record is dropped.
- If free = 0, every candidate is dropped.
- Each dropped record sets overflow and increments drop_cnt by one. Two drops in one cycle add 2. drop_cnt saturates at 2^CNT_W−1.
- Pointers wrap modulo DEPTH.
- out_valid = (count != 0). The output fields show the entry at the read pointer.
- Reset values:
  - out_valid=0, count=0, both pointers 0, overflow=0, drop_cnt=0.
  - out_type, out_pc, out_addr, out_data and out_be read 0; entry storage is cleared on reset.
- Reset asserted mid-stream discards all queued records immediately. Pushes and pops presented in the reset cycle are ignored.
- overflow and drop_cnt clear only on reset.

## Timing
- Push latency is 1: a record sampled at edge N appears on out_* after edge N when the queue was empty at edge N.
- Throughput: up to 2 pushes and 1 pop per cycle.
- The output payload is held stable while out_valid=1 && out_ready=0.
- out_ready is a don't-care while out_valid=0, and no pop occurs.
- Simultaneous pop and push into a full queue: the pushes fill the freed slot(s) and count is updated accordingly. No drop occurs if free ≥ candidates.
- The only combinational dependency of push acceptance is on out_ready; there is no combinational path from inputs to out_*.

## Configuration
- TRACE_SKIP_R0_EN defined: a GRF write with grf_addr=0 is not a candidate. It is neither queued nor counted as a drop.
- TRACE_SKIP_R0_EN undefined: $0 writes are queued like any other register write, with out_addr=0 and out_data set to the grf_wd presented.

## Test plan
- Single GRF write: grf_we=1, addr=8, pc=0x3000, wd=0x1234, out_ready=1. Next cycle out_valid=1, type=0, addr=8, data=0x1234, be=4'hF; then out_valid=0.
- Dual push: GRF (pc 0x3008) and DM (pc 0x300C, addr 0x10, be=4'h3) in the same cycle with out_ready=0. Drain yields GRF first, then DM with be=4'h3; count peaks at 2.
- Fill and overflow (DEPTH=8): 7 GRF pushes, then a dual push with out_ready=0. The GRF record is accepted, the DM record is dropped, overflow=1, drop_cnt=1; draining yields 8 records in order.
- Full with pop: queue full, out_ready=1 and one GRF push in the same cycle. The record is accepted, count stays 8, drop_cnt is unchanged.
- $0 filter: grf_addr=0 push.
  - With TRACE_SKIP_R0_EN: out_valid stays 0 and drop_cnt=0.
  - Without it: one record with addr=0.
- Reset mid-stream: 5 queued records plus overflow=1, then reset for one cycle with a simultaneous push. Afterwards out_valid=0, overflow=0, drop_cnt=0, and the next push is delivered alone.
